jk_count_ctrl: RTL

//  Controller and sequencer for a WIDTH-bit counter built from JK flip-flop cells.
//  Per clock it drives each cell's J/K pair to hold, set, reset or toggle. This gives

---
 rtl/jk_count_ctrl_pkg.sv | 36 +++
 rtl/jk_count_ctrl_if.sv | 27 ++
 rtl/jk_count_ctrl_cell.sv | 27 ++
 rtl/jk_count_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/jk_count_ctrl_pkg.sv
// Shared definitions for the JK-cell counter controller: state encodings,
// JK operation codes and the per-bit J/K selection helper.
package jk_count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Bit 1 is J, bit 0 is K
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_op_t;

    // Choose the JK operation that moves one cell from cur to nxt.
    // Counting steps use toggles; loads, wraps and restarts use explicit set/reset.
    function automatic jk_op_t jk_select(input logic cur, input logic nxt, input logic tog_mode);
        jk_op_t op;
        if (cur == nxt) begin
            op = JK_HOLD;
        end else if (tog_mode) begin
            op = JK_TOG;
        end else if (nxt) begin
            op = JK_SET;
        end else begin
            op = JK_RST;
        end
        return op;
    endfunction

endpackage

// File: rtl/jk_count_ctrl_if.sv
// Control and status bundle for the JK-cell counter controller.
interface jk_count_ctrl_if #(parameter int WIDTH = 4);

    logic             start;
    logic             halt;
    logic             hold;
    logic             dir;
    logic             cont;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output start, halt, hold, dir, cont, load, load_val, limit,
        input  q, tc, busy, done
    );

    modport slave (
        input  start, halt, hold, dir, cont, load, load_val, limit,
        output q, tc, busy, done
    );

endinterface

// File: rtl/jk_count_ctrl_cell.sv
// One JK flip-flop cell with asynchronous active-low clear.
module jk_count_ctrl_cell (
    input  logic clk,
    input  logic clear,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qnot
);

    // Classic JK behaviour: hold, reset, set or toggle on each rising edge
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    assign qnot = ~q;

endmodule

// File: rtl/jk_count_ctrl.sv
// Sequencer for a WIDTH-bit counter built from synchronously clocked JK cells.
// Works out the next counter value each cycle, then drives every cell's J/K
// pair so the cells land on that value at the next edge.
module jk_count_ctrl
    import jk_count_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           clear,
    jk_count_ctrl_if.slave bus
);

    state_t           state;
    state_t           nstate;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qnot;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             ntc;
    logic             tc;
    logic             tog_mode;
    logic             zero;

    // All cells at 0 means every inverted output is high
    assign zero = &qnot;

    // Next state, next count value and terminal-step detection
    always_comb begin
        nstate   = state;
        nq       = q;
        ntc      = 1'b0;
        tog_mode = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.load) begin
                    nq = bus.load_val;
                end
                if (bus.start) begin
                    nstate = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.halt) begin
                    nstate = ST_IDLE;
                end else if (bus.hold) begin
                    nstate = ST_HOLD;
                end else if (bus.dir) begin
                    if (q >= bus.limit) begin
                        ntc = 1'b1;
                        if (bus.cont) begin
                            nq = '0;
                        end else begin
                            nstate = ST_DONE;
                        end
                    end else begin
                        nq       = q + WIDTH'(1);
                        tog_mode = 1'b1;
                    end
                end else begin
                    if (zero) begin
                        ntc = 1'b1;
                        if (bus.cont) begin
                            nq = bus.limit;
                        end else begin
                            nstate = ST_DONE;
                        end
                    end else begin
                        nq       = q - WIDTH'(1);
                        tog_mode = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.halt) begin
                    nstate = ST_IDLE;
                end else if (!bus.hold) begin
                    nstate = ST_RUN;
                end
            end
            default: begin
                if (bus.halt) begin
                    nstate = ST_IDLE;
                end else if (bus.load) begin
                    nstate = ST_IDLE;
                    nq     = bus.load_val;
                end else if (bus.start) begin
                    nstate = ST_RUN;
                    nq     = bus.dir ? '0 : bus.limit;
                end
            end
        endcase
    end

    // Translate the q -> nq change into per-cell J/K operations
    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j[i], k[i]} = jk_select(q[i], nq[i], tog_mode);
        end
    end

    // The counter cells themselves, all on the shared clock
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_count_ctrl_cell u_cell (
            .clk   (clk),
            .clear (clear),
            .j     (j[g]),
            .k     (k[g]),
            .q     (q[g]),
            .qnot  (qnot[g])
        );
    end

    // State register and one-cycle terminal-count pulse
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= ST_IDLE;
            tc    <= 1'b0;
        end else begin
            state <= nstate;
            tc    <= ntc;
        end
    end

    assign bus.q    = q;
    assign bus.tc   = tc;
    assign bus.busy = (state == ST_RUN) || (state == ST_HOLD);
    assign bus.done = (state == ST_DONE);

endmodule
